// File: rtl/jelly3_img_demosaic_param_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : jelly3_img_demosaic_param_ctl
//  Purpose  : Frame-synchronous Bayer phase update, frame counting, timeout
//             and overrun supervision for the demosaic core.
//  Revision : 1.0  initial release
// ============================================================================

module jelly3_img_demosaic_param_ctl #(
    parameter int  TIMEOUT_BITS     = 24,
    parameter int  FRAME_COUNT_BITS = 16,
    parameter type phase_t          = logic [1:0]
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cke,

    input  phase_t                      cfg_phase,
    input  logic                        cfg_update,
    input  logic [TIMEOUT_BITS-1:0]     cfg_timeout,
    input  logic                        cfg_clear,

    input  logic                        mon_valid,
    input  logic                        mon_row_first,
    input  logic                        mon_row_last,
    input  logic                        mon_col_first,
    input  logic                        mon_col_last,

    output phase_t                      param_phase,
    output logic                        update_pending,
    output logic                        busy,
    output logic [FRAME_COUNT_BITS-1:0] frame_count,
    output logic                        err_timeout,
    output logic                        err_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0]     TMO_ONE   = TIMEOUT_BITS'(1);
    localparam logic [FRAME_COUNT_BITS-1:0] FRAME_ONE = FRAME_COUNT_BITS'(1);

    state_t                        state_q,     state_d;
    phase_t                        phase_q,     phase_d;
    phase_t                        shadow_q,    shadow_d;
    logic                          pending_q,   pending_d;
    logic [FRAME_COUNT_BITS-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TIMEOUT_BITS-1:0]       tmo_cnt_q,   tmo_cnt_d;
    logic                          err_tmo_q,   err_tmo_d;
    logic                          err_ovr_q,   err_ovr_d;

    logic                          fs;
    logic                          fe;
    logic                          tmo_hit;
    logic                          apply;

    assign fs      = cke & mon_valid & mon_row_first & mon_col_first;
    assign fe      = cke & mon_valid & mon_row_last  & mon_col_last;
    assign tmo_hit = (cfg_timeout != '0) && (tmo_cnt_q == (cfg_timeout - TMO_ONE));
    assign apply   = pending_q & cke & ((state_q == IDLE) | fs);

    // Configuration side: the shadow follows cfg_update on every clk, even
    // when the stream is stalled; an apply with a coincident update writes
    // the incoming phase straight through.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        phase_d   = phase_q;

        if (cfg_update) begin
            shadow_d  = cfg_phase;
            pending_d = 1'b1;
        end

        if (apply) begin
            phase_d   = cfg_update ? cfg_phase : shadow_q;
            pending_d = 1'b0;
        end
    end

    // Stream side: everything here is frozen while cke is low, including
    // the error flags, so a clear request only takes effect on cke cycles.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_tmo_d   = err_tmo_q;
        err_ovr_d   = err_ovr_q;

        if (cke) begin
            if (cfg_clear) begin
                err_tmo_d = 1'b0;
                err_ovr_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (fs && fe) begin
                        frame_cnt_d = frame_cnt_q + FRAME_ONE;
                    end else if (fs) begin
                        state_d   = FRAME;
                        tmo_cnt_d = '0;
                    end
                end

                FRAME: begin
                    if (fe) begin
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt_q + FRAME_ONE;
                    end else if (fs) begin
                        tmo_cnt_d = '0;
                        err_ovr_d = 1'b1;
                    end else if (tmo_hit) begin
                        state_d   = IDLE;
                        err_tmo_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_tmo_q   <= err_tmo_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign param_phase    = phase_q;
    assign update_pending = pending_q;
    assign busy           = (state_q == FRAME);
    assign frame_count    = frame_cnt_q;
    assign err_timeout    = err_tmo_q;
    assign err_overrun    = err_ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_jelly3_img_demosaic_param_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jelly3_img_demosaic_param_ctl
//  Purpose  : Directed and randomized self-checking bench with a behavioural
//             frame/phase model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_jelly3_img_demosaic_param_ctl;

    localparam int TIMEOUT_BITS     = 24;
    localparam int FRAME_COUNT_BITS = 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        cke;
    logic [1:0]                  cfg_phase;
    logic                        cfg_update;
    logic [TIMEOUT_BITS-1:0]     cfg_timeout;
    logic                        cfg_clear;
    logic                        mon_valid;
    logic                        mon_row_first;
    logic                        mon_row_last;
    logic                        mon_col_first;
    logic                        mon_col_last;
    logic [1:0]                  param_phase;
    logic                        update_pending;
    logic                        busy;
    logic [FRAME_COUNT_BITS-1:0] frame_count;
    logic                        err_timeout;
    logic                        err_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: "in a frame", how many cke cycles the frame has aged,
    // the phase in use, a staged request and the completed-frame tally.
    bit       m_in_frame;
    int       m_age;
    bit [1:0] m_phase;
    bit [1:0] m_staged;
    bit       m_has_staged;
    int       m_frames;
    bit       m_err_tmo;
    bit       m_err_ovr;

    jelly3_img_demosaic_param_ctl #(
        .TIMEOUT_BITS     (TIMEOUT_BITS),
        .FRAME_COUNT_BITS (FRAME_COUNT_BITS),
        .phase_t          (logic [1:0])
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cke            (cke),
        .cfg_phase      (cfg_phase),
        .cfg_update     (cfg_update),
        .cfg_timeout    (cfg_timeout),
        .cfg_clear      (cfg_clear),
        .mon_valid      (mon_valid),
        .mon_row_first  (mon_row_first),
        .mon_row_last   (mon_row_last),
        .mon_col_first  (mon_col_first),
        .mon_col_last   (mon_col_last),
        .param_phase    (param_phase),
        .update_pending (update_pending),
        .busy           (busy),
        .frame_count    (frame_count),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit frame_start;
        bit frame_end;
        bit apply_now;
        bit [1:0] staged_before;

        frame_start   = cke && mon_valid && mon_row_first && mon_col_first;
        frame_end     = cke && mon_valid && mon_row_last  && mon_col_last;
        staged_before = m_staged;

        if (reset) begin
            m_in_frame   = 0;
            m_age        = 0;
            m_phase      = 0;
            m_staged     = 0;
            m_has_staged = 0;
            m_frames     = 0;
            m_err_tmo    = 0;
            m_err_ovr    = 0;
            return;
        end

        apply_now = m_has_staged && cke && (!m_in_frame || frame_start);
        if (cfg_update) begin
            m_staged     = cfg_phase;
            m_has_staged = 1;
        end
        if (apply_now) begin
            m_phase      = cfg_update ? cfg_phase : staged_before;
            m_has_staged = 0;
        end

        if (!cke) return;

        if (cfg_clear) begin
            m_err_tmo = 0;
            m_err_ovr = 0;
        end

        if (!m_in_frame) begin
            if (frame_start && frame_end) begin
                m_frames = (m_frames + 1) % (1 << FRAME_COUNT_BITS);
            end else if (frame_start) begin
                m_in_frame = 1;
                m_age      = 0;
            end
        end else if (frame_end) begin
            m_in_frame = 0;
            m_frames   = (m_frames + 1) % (1 << FRAME_COUNT_BITS);
        end else if (frame_start) begin
            m_age     = 0;
            m_err_ovr = 1;
        end else if (cfg_timeout != 0 && m_age + 1 >= int'(cfg_timeout)) begin
            m_in_frame = 0;
            m_err_tmo  = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, "/phase"},   32'(param_phase),    32'(m_phase));
        check({tag, "/pending"}, 32'(update_pending), 32'(m_has_staged));
        check({tag, "/busy"},    32'(busy),           32'(m_in_frame));
        check({tag, "/frames"},  32'(frame_count),    32'(m_frames));
        check({tag, "/err_tmo"}, 32'(err_timeout),    32'(m_err_tmo));
        check({tag, "/err_ovr"}, 32'(err_overrun),    32'(m_err_ovr));
    endtask

    task automatic set_mon(input bit v, input bit rf, input bit rl, input bit cf, input bit cl);
        mon_valid     = v;
        mon_row_first = rf;
        mon_row_last  = rl;
        mon_col_first = cf;
        mon_col_last  = cl;
    endtask

    task automatic quiet();
        cke        = 1;
        cfg_update = 0;
        cfg_clear  = 0;
        set_mon(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        tick("rst");
        tick("rst");
        check("rst_phase",  32'(param_phase),    0);
        check("rst_busy",   32'(busy),           0);
        check("rst_frames", 32'(frame_count),    0);
        check("rst_pend",   32'(update_pending), 0);
        reset = 0;
    endtask

    initial begin
        reset       = 1;
        cfg_phase   = 0;
        cfg_timeout = 0;
        quiet();

        // Idle apply
        do_reset();
        cfg_phase  = 2;
        cfg_update = 1;
        tick("idle_upd");
        cfg_update = 0;
        check("idle_pend_set", 32'(update_pending), 1);
        tick("idle_apply");
        check("idle_phase", 32'(param_phase), 2);
        check("idle_pend_clr", 32'(update_pending), 0);

        // Mid-frame hold
        do_reset();
        set_mon(1, 1, 0, 1, 0);
        tick("hold_fs");
        set_mon(0, 0, 0, 0, 0);
        tick("hold_mid");
        cfg_phase  = 3;
        cfg_update = 1;
        tick("hold_upd");
        cfg_update = 0;
        repeat (3) tick("hold_wait");
        check("hold_phase_frame", 32'(param_phase), 0);
        set_mon(1, 0, 1, 0, 1);
        tick("hold_fe");
        set_mon(0, 0, 0, 0, 0);
        check("hold_phase_fe", 32'(param_phase), 0);
        check("hold_busy_fe", 32'(busy), 0);
        tick("hold_apply");
        check("hold_phase_applied", 32'(param_phase), 3);
        check("hold_frames", 32'(frame_count), 1);

        // Timeout
        do_reset();
        cfg_timeout = 10;
        set_mon(1, 1, 0, 1, 0);
        tick("tmo_fs");
        set_mon(0, 0, 0, 0, 0);
        repeat (9) tick("tmo_wait");
        check("tmo_busy_before", 32'(busy), 1);
        tick("tmo_hit");
        check("tmo_busy_after", 32'(busy), 0);
        check("tmo_flag", 32'(err_timeout), 1);
        check("tmo_frames", 32'(frame_count), 0);
        cfg_clear = 1;
        tick("tmo_clear");
        cfg_clear = 0;
        check("tmo_cleared", 32'(err_timeout), 0);

        // Overrun
        do_reset();
        cfg_timeout = 0;
        set_mon(1, 1, 0, 1, 0);
        tick("ovr_fs1");
        set_mon(0, 0, 0, 0, 0);
        repeat (5) tick("ovr_wait");
        set_mon(1, 1, 0, 1, 0);
        tick("ovr_fs2");
        set_mon(0, 0, 0, 0, 0);
        check("ovr_flag", 32'(err_overrun), 1);
        check("ovr_busy", 32'(busy), 1);
        tick("ovr_mid");
        set_mon(1, 0, 1, 0, 1);
        tick("ovr_fe");
        set_mon(0, 0, 0, 0, 0);
        check("ovr_frames", 32'(frame_count), 1);

        // cke gating and frame counter wrap
        do_reset();
        for (int f = 0; f < 5; f++) begin
            cke = 1;
            set_mon(1, 1, 0, 1, 0);
            tick("wrap_fs");
            cke = 0;
            set_mon(1, 0, 1, 0, 1);
            tick("wrap_fe_gated");
            check("wrap_gated_busy", 32'(busy), 1);
            cke = 1;
            tick("wrap_fe");
            cke = 0;
            set_mon(1, 1, 0, 1, 0);
            tick("wrap_fs_gated");
            check("wrap_gated_idle", 32'(busy), 0);
        end
        quiet();
        check("wrap_frames", 32'(frame_count), 1);

        // Reset mid-frame with a pending update
        do_reset();
        set_mon(1, 1, 0, 1, 0);
        tick("rmf_fs");
        set_mon(0, 0, 0, 0, 0);
        cfg_phase  = 1;
        cfg_update = 1;
        tick("rmf_upd");
        check("rmf_pending", 32'(update_pending), 1);
        reset = 1;
        set_mon(1, 1, 0, 1, 0);
        tick("rmf_reset");
        cfg_update = 0;
        check("rmf_busy", 32'(busy), 0);
        check("rmf_pend", 32'(update_pending), 0);
        check("rmf_phase", 32'(param_phase), 0);
        reset = 0;
        tick("rmf_fresh_fs");
        set_mon(0, 0, 0, 0, 0);
        check("rmf_fresh_busy", 32'(busy), 1);
        check("rmf_fresh_ovr", 32'(err_overrun), 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) cfg_timeout = TIMEOUT_BITS'($urandom_range(0, 12));
            reset         = ($urandom_range(0, 127) == 0);
            cke           = ($urandom_range(0, 3) != 0);
            cfg_phase     = 2'($urandom_range(0, 3));
            cfg_update    = ($urandom_range(0, 7) == 0);
            cfg_clear     = ($urandom_range(0, 15) == 0);
            mon_valid     = ($urandom_range(0, 1) == 1);
            mon_row_first = ($urandom_range(0, 3) == 0);
            mon_col_first = ($urandom_range(0, 3) == 0);
            mon_row_last  = ($urandom_range(0, 3) == 0);
            mon_col_last  = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jelly3_img_demosaic_param_ctl.md
JELLY3_IMG_DEMOSAIC_PARAM_CTL -- requirements
Module: jelly3_img_demosaic_param_ctl

Interface
REQ-001 Parameters SHALL be, one per line:
- TIMEOUT_BITS, default 24: timeout counter width.
- FRAME_COUNT_BITS, default 16: frame counter width.
- phase_t, default logic [1:0]: Bayer phase type.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cke  in  1  clock enable for stream-side logic.
- cfg_phase  in  2  requested Bayer phase.
- cfg_update  in  1  one-cycle request to stage cfg_phase.
- cfg_timeout  in  TIMEOUT_BITS  frame timeout in cke cycles; 0 disables.
- cfg_clear  in  1  clears the sticky error flags.
- mon_valid, mon_row_first, mon_row_last, mon_col_first, mon_col_last  in  1 each  stream monitor taps from the demosaic core input.
- param_phase  out  2  phase driven to the demosaic core.
- update_pending  out  1  a staged phase is not yet applied.
- busy  out  1  a frame is in progress.
- frame_count  out  FRAME_COUNT_BITS  completed frames.
- err_timeout  out  1  sticky timeout flag.
- err_overrun  out  1  sticky flag for a restart without frame end.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high, with the clock and reset ports named clk and reset.

Function
REQ-004 Event definitions:
- fs (frame start) = cke & mon_valid & mon_row_first & mon_col_first.
- fe (frame end) = cke & mon_valid & mon_row_last & mon_col_last.
REQ-005 FSM states SHALL be IDLE and FRAME; busy SHALL be 1 exactly when the state is FRAME.
REQ-006 IDLE transitions:
- fs without fe: go to FRAME.
- fs with fe in the same cycle (1-pixel frame): stay in IDLE and increment frame_count.
REQ-007 FRAME transitions:
- fe: go to IDLE and increment frame_count.
- fs without fe: stay in FRAME, restart the timeout counter and set err_overrun.
REQ-008 In FRAME, fs and fe in the same cycle SHALL count as a completed frame, go to IDLE and not set err_overrun.
REQ-009 The timeout counter SHALL behave as follows:
- clears on entering FRAME.
- increments on each cke cycle while in FRAME.
- when cfg_timeout != 0 and the counter reaches cfg_timeout-1 with no fe, the state goes to IDLE and err_timeout is set.
- frame_count does not change on a timeout.
REQ-010 cfg_update SHALL be sampled every clk regardless of cke: the shadow register takes cfg_phase and update_pending is set.
REQ-011 The staged phase SHALL be applied when update_pending=1 and cke=1 and either of these holds:
- the state is IDLE; or
- fs occurs.
On apply, param_phase takes the shadow on that edge and update_pending clears.
REQ-012 If cfg_update and an apply coincide, the apply SHALL use the incoming cfg_phase (write-through) and update_pending SHALL end at 0.
REQ-013 Phase changes while in FRAME:
- param_phase SHALL never change in FRAME, except by an apply triggered by fs.
- a cfg_update during FRAME SHALL hold until fe or timeout, then apply on the next cke cycle in IDLE.
REQ-014 Repeated cfg_update before an apply SHALL overwrite the shadow; the last value wins.
REQ-015 frame_count SHALL wrap modulo 2^FRAME_COUNT_BITS.
REQ-016 cfg_clear SHALL clear err_timeout and err_overrun. A simultaneous set condition SHALL take priority, leaving the flag at 1.
REQ-017 With cke=0, state, counters, param_phase and errors SHALL hold; only the shadow and update_pending respond (REQ-010).
REQ-018 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-019 On reset=1 at a clk edge, the following SHALL hold on the next cycle:
- state is IDLE.
- param_phase=0, shadow=0, update_pending=0, busy=0.
- frame_count=0, timeout counter=0, err_timeout=0, err_overrun=0.
REQ-020 Reset SHALL override cke, cfg_update and all stream events in the same cycle. A reset mid-frame SHALL discard the frame and any pending update.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Idle apply: cfg_phase=2, cfg_update pulse in IDLE with cke=1 -> the next cycle shows update_pending=1; one cycle later param_phase=2 and update_pending=0.
- Mid-frame hold: fs, then cfg_update(phase=3) in FRAME -> param_phase unchanged until fe; applied on the first cke cycle after IDLE; frame_count=1.
- Timeout: cfg_timeout=10, fs, no fe -> busy falls after 10 cke cycles; err_timeout=1; frame_count=0; cfg_clear returns err_timeout to 0.
- Overrun: fs, 5 cycles, fs again -> err_overrun=1; busy stays 1; a later fe gives frame_count=1.
- cke gating and wrap: FRAME_COUNT_BITS=2, 5 frames with cke toggling -> frame_count=1; no state change in cke=0 cycles.
- Reset mid-frame with pending update -> all outputs at their REQ-019 values; a subsequent fs starts a fresh frame.
